// File: rtl/conv_writeback_pkg.sv
// Shared definitions for the convolution write-back path: default geometry,
// word widths and the write-back sequencer state encoding.
package conv_pkg;

    localparam int IMG_W     = 48;
    localparam int K         = 3;
    localparam int OUT_W     = IMG_W - K + 1;
    localparam int OUT_H     = 46;
    localparam int OUT_PITCH = 46;
    localparam int ADDR_W    = 13;
    localparam int ACC_W     = 32;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_writeback_if.sv
// Result stream in and RAM write port out of the write-back block.
// The slave modport is the write-back block; master is whoever feeds
// results and observes the RAM writes.
interface conv_writeback_if #(
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int ACC_W  = conv_pkg::ACC_W,
    parameter int DATA_W = conv_pkg::DATA_W
);

    logic                     res_valid;
    logic signed [ACC_W-1:0]  res_data;
    logic                     res_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;

    modport master (
        output res_valid, res_data,
        input  res_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  res_valid, res_data,
        output res_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/conv_writeback_sat_relu.sv
// Combinational formatter: optional ReLU followed by signed saturation
// from the accumulator width down to the stored word width.
module sat_relu #(
    parameter int ACC_W  = 32,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu,
    output logic signed [DATA_W-1:0] sat
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] v;

    // Zero negatives when ReLU is on, then clip into the storable range
    always_comb begin
        v = acc;
        if (relu && (acc < 0)) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = v[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv_writeback.sv
// Write-back sequencer for one output feature map: accepts MAC results,
// formats them and writes them to the output RAM at row-pitched addresses.
// Addresses wrap modulo 2^ADDR_W without any indication.
module conv_writeback #(
    parameter int IMG_W     = conv_pkg::IMG_W,
    parameter int K         = conv_pkg::K,
    parameter int OUT_W     = IMG_W - K + 1,
    parameter int OUT_H     = conv_pkg::OUT_H,
    parameter int OUT_PITCH = conv_pkg::OUT_PITCH,
    parameter int ADDR_W    = conv_pkg::ADDR_W,
    parameter int ACC_W     = conv_pkg::ACC_W,
    parameter int DATA_W    = conv_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              relu_en,
    conv_writeback_if.slave   bus,
    output logic              busy,
    output logic              done
);

    import conv_pkg::*;

    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

    state_t                   state;
    state_t                   next_state;
    logic [ADDR_W-1:0]        row_base;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     relu_q;
    logic                     transfer;
    logic                     last_xfer;
    logic signed [DATA_W-1:0] fmt_data;

    assign bus.res_ready = (state == RUN);
    assign busy          = (state == RUN);
    assign done          = (state == DONE);
    assign transfer      = (state == RUN) && en && bus.res_valid;
    assign last_xfer     = transfer && (col == COL_LAST) && (row == ROW_LAST);

    sat_relu #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat_relu (
        .acc  (bus.res_data),
        .relu (relu_q),
        .sat  (fmt_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; dropping en always falls back to IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && en) next_state = RUN;
            RUN: begin
                if (!en) begin
                    next_state = IDLE;
                end else if (last_xfer) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Column/row position and current row base address
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            relu_q   <= 1'b0;
        end else if (state == IDLE && start) begin
            col      <= '0;
            row      <= '0;
            row_base <= base_addr;
            relu_q   <= relu_en;
        end else if (transfer) begin
            if (col == COL_LAST) begin
                col      <= '0;
                row      <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                row_base <= row_base + ADDR_W'(OUT_PITCH);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Registered RAM write port; address and data hold between writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= transfer;
            if (transfer) begin
                bus.wr_addr <= row_base + ADDR_W'(col);
                bus.wr_data <= fmt_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_writeback.sv
// Directed bench for conv_writeback: a formatting vector table plus
// hand-written map sequences. A second instance with row pitch 48 shares
// the same stimulus.
module tb_conv_writeback;

    localparam int NPIX = 46 * 46;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        en;
    logic [12:0] base_addr;
    logic        relu_en;
    logic        busy, done, busy48, done48;

    int checks   = 0;
    int failures = 0;

    conv_writeback_if #(.ADDR_W(13), .ACC_W(32), .DATA_W(16)) bus ();
    conv_writeback_if #(.ADDR_W(13), .ACC_W(32), .DATA_W(16)) bus48 ();

    assign bus48.res_valid = bus.res_valid;
    assign bus48.res_data  = bus.res_data;

    conv_writeback #(.OUT_PITCH(46)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .base_addr (base_addr),
        .relu_en   (relu_en),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done)
    );

    conv_writeback #(.OUT_PITCH(48)) dut48 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .base_addr (base_addr),
        .relu_en   (relu_en),
        .bus       (bus48.slave),
        .busy      (busy48),
        .done      (done48)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        int          data;
        logic        relu;
        int          expect_data;
    } fmt_vec_t;

    fmt_vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int d);
        bus.res_valid = v;
        bus.res_data  = d;
        tick();
    endtask

    task automatic startMap(input int base, input logic relu);
        start     = 1'b1;
        en        = 1'b1;
        base_addr = 13'(base);
        relu_en   = relu;
        bus.res_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic abortMap();
        en = 1'b0;
        bus.res_valid = 1'b0;
        tick();
        en = 1'b1;
    endtask

    // One complete map with optional random res_valid gaps; both pitches
    // are compared against row*pitch+col addressing
    task automatic fullRun(input int base, input int gap_pct, input string tag);
        int     n = 0, r = 0, c = 0, mm = 0, writes = 0, dones = 0;
        int     prev_addr = 0, prev_data = 0, cycles = 0;
        logic   v;
        startMap(base, 1'b0);
        while (n < NPIX && cycles < 20000) begin
            cycles++;
            v = (gap_pct == 0) ? 1'b1 : ($urandom_range(99, 0) >= gap_pct);
            if (bus.res_ready !== 1'b1) mm++;
            applyStimulus(v, v ? (n - 1000) : 32'h00AB_CDEF);
            writes += int'(bus.wr_en);
            dones  += int'(done);
            if (v) begin
                if (bus.wr_en !== 1'b1) mm++;
                if (int'(bus.wr_addr) != (base + r * 46 + c) % 8192) mm++;
                if (int'(bus48.wr_addr) != (base + r * 48 + c) % 8192) mm++;
                if (int'(bus.wr_data) != n - 1000) mm++;
                n++;
                if (c == 45) begin c = 0; r++; end else c++;
                if (n == NPIX) begin
                    checkOutput({tag, "_done_with_last"}, {done, bus.wr_en, done48}, 3'b111);
                    checkOutput({tag, "_last_addr"}, bus.wr_addr, (base + 45 * 46 + 45) % 8192);
                end
            end else begin
                if (bus.wr_en !== 1'b0) mm++;
                if (int'(bus.wr_addr) != prev_addr) mm++;
                if (int'($signed(bus.wr_data)) != prev_data) mm++;
            end
            prev_addr = int'(bus.wr_addr);
            prev_data = int'($signed(bus.wr_data));
        end
        checkOutput({tag, "_mismatches"}, mm, 0);
        checkOutput({tag, "_write_count"}, writes, NPIX);
        checkOutput({tag, "_done_pulses"}, dones, 1);
        checkOutput({tag, "_ready_in_done"}, {bus.res_ready, busy}, 2'b00);
        applyStimulus(1'b1, 5);
        checkOutput({tag, "_idle_after"}, {done, busy, bus.wr_en, bus.res_ready}, 4'b0000);
        bus.res_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{70000,   1'b0,  32767};
        vecs[1]  = '{-70000,  1'b0, -32768};
        vecs[2]  = '{-5,      1'b1,  0};
        vecs[3]  = '{1234,    1'b0,  1234};
        vecs[4]  = '{-5,      1'b0, -5};
        vecs[5]  = '{32767,   1'b0,  32767};
        vecs[6]  = '{32768,   1'b0,  32767};
        vecs[7]  = '{-32768,  1'b0, -32768};
        vecs[8]  = '{-32769,  1'b0, -32768};
        vecs[9]  = '{-70000,  1'b1,  0};
        vecs[10] = '{70000,   1'b1,  32767};

        rst_n = 1'b0; start = 1'b0; en = 1'b0; base_addr = '0; relu_en = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = 0;
        tick(); tick();
        checkOutput("reset_outputs", {bus.wr_en, busy, done, bus.res_ready}, 4'b0000);
        checkOutput("reset_addr_data", {bus.wr_addr, bus.wr_data}, 0);
        rst_n = 1'b1; en = 1'b1;
        applyStimulus(1'b1, 9);
        checkOutput("idle_no_accept", {bus.wr_en, bus.res_ready}, 2'b00);

        // Formatting table: each vector is the first transfer of a fresh map
        for (int i = 0; i < 11; i++) begin
            startMap(300, vecs[i].relu);
            checkOutput("fmt_busy", {busy, bus.res_ready}, 2'b11);
            applyStimulus(1'b1, vecs[i].data);
            checkOutput($sformatf("fmt_data_%0d", i), $signed(bus.wr_data), vecs[i].expect_data);
            checkOutput($sformatf("fmt_addr_%0d", i), {bus.wr_en, bus.wr_addr}, {1'b1, 13'd300});
            abortMap();
        end

        // Reset in the middle of a map, then restart from col 0 row 0
        startMap(100, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i);
        checkOutput("pre_reset_addr", bus.wr_addr, 109);
        rst_n = 1'b0;
        applyStimulus(1'b1, 77);
        checkOutput("midrun_reset", {bus.wr_en, busy, done, bus.res_ready, bus.wr_addr, bus.wr_data}, 0);
        rst_n = 1'b1;
        startMap(200, 1'b0);
        applyStimulus(1'b1, 7);
        checkOutput("restart_addr", bus.wr_addr, 200);
        checkOutput("restart_data", bus.wr_data, 7);
        abortMap();

        // Row boundary for both pitches; a start inside RUN is ignored
        startMap(0, 1'b0);
        for (int i = 0; i < 47; i++) begin
            if (i == 10) begin start = 1'b1; base_addr = 13'd5000; end
            applyStimulus(1'b1, i);
            start = 1'b0;
            if (i == 10) checkOutput("start_ignored", bus.wr_addr, 10);
            if (i == 45) checkOutput("p48_col45", bus48.wr_addr, 45);
            if (i == 46) checkOutput("p48_row1", bus48.wr_addr, 48);
            if (i == 46) checkOutput("p46_row1", bus.wr_addr, 46);
        end
        abortMap();

        fullRun(100, 0, "cont");
        fullRun(100, 30, "gaps");

        // en dropped on transfer 500: no write, no done, stays IDLE
        startMap(100, 1'b0);
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, i);
        checkOutput("pre_drop_addr", bus.wr_addr, 100 + 10 * 46 + 39);
        en = 1'b0;
        applyStimulus(1'b1, 500);
        checkOutput("en_drop", {bus.wr_en, busy, done, bus.res_ready}, 4'b0000);
        en = 1'b1;
        applyStimulus(1'b1, 501);
        checkOutput("en_drop_idle", {bus.wr_en, busy, done}, 3'b000);

        // Address wrap modulo 2^13
        startMap(8190, 1'b0);
        for (int i = 0; i < 47; i++) begin
            applyStimulus(1'b1, i);
            if (i == 1)  checkOutput("wrap_8191", bus.wr_addr, 8191);
            if (i == 2)  checkOutput("wrap_0", bus.wr_addr, 0);
            if (i == 46) checkOutput("wrap_row1", bus.wr_addr, 44);
        end
        abortMap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
